// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states, default widths.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int OP_W  = 3;

  localparam logic [2:0] ALU_ADD     = 3'b000;
  localparam logic [2:0] ALU_SUB     = 3'b001;
  localparam logic [2:0] ALU_AND     = 3'b010;
  localparam logic [2:0] ALU_OR      = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SLL     = 3'b101;
  localparam logic [2:0] ALU_SRL     = 3'b110;
  localparam logic [2:0] ALU_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// port that was not granted last. Purely combinational, one-hot output.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] grant
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    localparam logic ME = 1'(gi);
    assign grant[gi] = req[gi] & (~req[1-gi] | (last_owner != ME));
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters, one operation
// in flight at a time: IDLE accepts, EXEC drives the ALU, RESP holds the result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int OP_W  = alu_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req_valid,
  output logic             p0_req_ready,
  input  logic [WIDTH-1:0] p0_req_a,
  input  logic [WIDTH-1:0] p0_req_b,
  input  logic [OP_W-1:0]  p0_req_op,
  output logic             p0_rsp_valid,
  input  logic             p0_rsp_ready,
  output logic [WIDTH-1:0] p0_rsp_result,
  output logic             p0_rsp_err,
  input  logic             p1_req_valid,
  output logic             p1_req_ready,
  input  logic [WIDTH-1:0] p1_req_a,
  input  logic [WIDTH-1:0] p1_req_b,
  input  logic [OP_W-1:0]  p1_req_op,
  output logic             p1_rsp_valid,
  input  logic             p1_rsp_ready,
  output logic [WIDTH-1:0] p1_rsp_result,
  output logic             p1_rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  state_t           state_reg, state_next;
  logic             owner_reg, last_owner_reg;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg;
  logic [OP_W-1:0]  op_reg;
  logic             err_reg;

  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, grant;
  logic [WIDTH-1:0] rsp_result [2];
  logic [1:0]       rsp_err;
  logic             accept, illegal;

  assign req_valid = {p1_req_valid, p0_req_valid};
  assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};
  assign illegal   = (op_reg == OP_W'(ALU_ILLEGAL));
  assign accept    = (state_reg == S_IDLE) && (|grant);

  rr_arb2 u_rr_arb2 (
    .req        (req_valid),
    .last_owner (last_owner_reg),
    .grant      (grant)
  );

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    rsp_valid  = '0;
    case (state_reg)
      S_IDLE: begin
        req_ready = grant;
        if (|grant) state_next = S_EXEC;
      end
      S_EXEC: state_next = S_RESP;
      S_RESP: begin
        rsp_valid = owner_reg ? 2'b10 : 2'b01;
        if (rsp_ready[owner_reg]) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // last_owner resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= '0;
      result_reg     <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (accept) begin
        owner_reg      <= grant[1];
        last_owner_reg <= grant[1];
        a_reg          <= grant[1] ? p1_req_a  : p0_req_a;
        b_reg          <= grant[1] ? p1_req_b  : p0_req_b;
        op_reg         <= grant[1] ? p1_req_op : p0_req_op;
      end
      if (state_reg == S_EXEC) begin
        result_reg <= illegal ? '0 : alu_result;
        err_reg    <= illegal;
      end
    end
  end

  // The illegal opcode never reaches the ALU; it sees a harmless ADD instead.
  assign alu_a  = a_reg;
  assign alu_b  = b_reg;
  assign alu_op = illegal ? OP_W'(ALU_ADD) : op_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign rsp_result[gi] = rsp_valid[gi] ? result_reg : '0;
    assign rsp_err[gi]    = rsp_valid[gi] & err_reg;
  end

  assign p0_req_ready  = req_ready[0];
  assign p1_req_ready  = req_ready[1];
  assign p0_rsp_valid  = rsp_valid[0];
  assign p1_rsp_valid  = rsp_valid[1];
  assign p0_rsp_result = rsp_result[0];
  assign p1_rsp_result = rsp_result[1];
  assign p0_rsp_err    = rsp_err[0];
  assign p1_rsp_err    = rsp_err[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a bench-side ALU model, a per-port
// scoreboard of expected responses, and one task per scenario.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
  logic [W-1:0] p0_req_a, p0_req_b, p0_rsp_result;
  logic [2:0]   p0_req_op;
  logic         p1_req_valid, p1_req_ready, p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
  logic [W-1:0] p1_req_a, p1_req_b, p1_rsp_result;
  logic [2:0]   p1_req_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;

  typedef struct packed {
    logic         err;
    logic [W-1:0] result;
  } rsp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic acc0, acc1;
  rsp_t exp_q0[$], exp_q1[$], got_q0[$], got_q1[$];
  int   grant_log[$];
  int   acc_cyc[$];

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_a(p0_req_a), .p0_req_b(p0_req_b), .p0_req_op(p0_req_op),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
    .p0_rsp_result(p0_rsp_result), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_a(p1_req_a), .p1_req_b(p1_req_b), .p1_req_op(p1_req_op),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
    .p1_rsp_result(p1_rsp_result), .p1_rsp_err(p1_rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a << b[4:0];
      3'b110:  return a >> b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic rsp_t expect_of(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    rsp_t r;
    if (op == 3'b111) r = '{err: 1'b1, result: '0};
    else              r = '{err: 1'b0, result: alu_fn(a, b, op)};
    return r;
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  // Called at a falling edge: records handshakes that the next rising edge will
  // take, then advances to the following falling edge.
  task automatic cycle();
    #1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst) begin
      if (p0_req_valid && p0_req_ready) begin
        exp_q0.push_back(expect_of(p0_req_a, p0_req_b, p0_req_op));
        grant_log.push_back(0);
        acc_cyc.push_back(cyc);
        acc0 = 1'b1;
        $display("[TB] cycle %0d: p0 accept a=%h b=%h op=%0d", cyc, p0_req_a, p0_req_b, p0_req_op);
      end
      if (p1_req_valid && p1_req_ready) begin
        exp_q1.push_back(expect_of(p1_req_a, p1_req_b, p1_req_op));
        grant_log.push_back(1);
        acc_cyc.push_back(cyc);
        acc1 = 1'b1;
        $display("[TB] cycle %0d: p1 accept a=%h b=%h op=%0d", cyc, p1_req_a, p1_req_b, p1_req_op);
      end
      if (p0_rsp_valid && p0_rsp_ready) begin
        got_q0.push_back('{err: p0_rsp_err, result: p0_rsp_result});
        $display("[TB] cycle %0d: p0 response result=%h err=%0b", cyc, p0_rsp_result, p0_rsp_err);
      end
      if (p1_rsp_valid && p1_rsp_ready) begin
        got_q1.push_back('{err: p1_rsp_err, result: p1_rsp_result});
        $display("[TB] cycle %0d: p1 response result=%h err=%0b", cyc, p1_rsp_result, p1_rsp_err);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  // Runs cycles until every accepted request has a response or the budget expires.
  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (got_q0.size() >= exp_q0.size() && got_q1.size() >= exp_q1.size()) break;
      cycle();
    end
  endtask

  task automatic clear_sb();
    exp_q0.delete(); exp_q1.delete(); got_q0.delete(); got_q1.delete();
    grant_log.delete(); acc_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p0_req_valid = 0; p1_req_valid = 0;
    p0_req_a = '0; p0_req_b = '0; p0_req_op = '0;
    p1_req_a = '0; p1_req_b = '0; p1_req_op = '0;
    p0_rsp_ready = 1; p1_rsp_ready = 1;
    cycle(); cycle();
    rst = 1'b0;
    clear_sb();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if ({p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, expected 000000",
               {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err});
    end
    tests++;
    if ({alu_a, alu_b, alu_op, p0_rsp_result, p1_rsp_result} !== '0) begin
      fails++;
      $display("FAIL reset_data: alu_a=%h alu_b=%h alu_op=%0d r0=%h r1=%h, expected all 0",
               alu_a, alu_b, alu_op, p0_rsp_result, p1_rsp_result);
    end
    cycle();
  endtask

  task automatic test_p0_only();
    p0_req_a = 10; p0_req_b = 5; p0_req_op = 3'b001; p0_req_valid = 1;
    #1;
    tests++;
    if ({p0_req_ready, p1_req_ready} !== 2'b10) begin
      fails++; $display("FAIL p0only_ready: got p0=%b p1=%b, expected p0=1 p1=0", p0_req_ready, p1_req_ready);
    end
    cycle();
    p0_req_valid = 0;
    #1;
    tests++;
    if (alu_a !== 10 || alu_b !== 5 || alu_op !== 3'b001 || p0_rsp_valid !== 1'b0) begin
      fails++; $display("FAIL p0only_exec: got a=%0d b=%0d op=%0d rv=%b, expected 10 5 1 0", alu_a, alu_b, alu_op, p0_rsp_valid);
    end
    cycle();
    #1;
    tests++;
    if (p0_rsp_valid !== 1'b1 || p0_rsp_result !== 5 || p0_rsp_err !== 1'b0) begin
      fails++; $display("FAIL p0only_resp: got v=%b r=%0d e=%b, expected v=1 r=5 e=0", p0_rsp_valid, p0_rsp_result, p0_rsp_err);
    end
    tests++;
    if ({p1_rsp_valid, p1_rsp_err, p1_rsp_result, p1_req_ready} !== '0) begin
      fails++; $display("FAIL p0only_p1quiet: got v=%b e=%b r=%h rdy=%b, expected 0", p1_rsp_valid, p1_rsp_err, p1_rsp_result, p1_req_ready);
    end
    cycle();
    #1;
    tests++;
    if (p0_rsp_valid !== 1'b0) begin
      fails++; $display("FAIL p0only_done: got rsp_valid=%b, expected 0", p0_rsp_valid);
    end
    drain(10);
    tests++;
    if (got_q0.size() != exp_q0.size() || got_q0.size() != 1) begin
      fails++; $display("FAIL p0only_count: got %0d responses, expected %0d", got_q0.size(), exp_q0.size());
    end
    while (got_q0.size() > 0 && exp_q0.size() > 0) begin
      rsp_t g, e;
      g = got_q0.pop_front(); e = exp_q0.pop_front();
      tests++;
      if (g !== e) begin fails++; $display("FAIL p0only_sb: got %h, expected %h", g, e); end
    end
    clear_sb();
  endtask

  task automatic test_tie();
    int want[4] = '{0, 1, 0, 1};
    do_reset();
    for (int r = 0; r < 2; r++) begin
      p0_req_a = 10; p0_req_b = 5; p0_req_op = 3'b000; p0_req_valid = 1;
      p1_req_a = 10; p1_req_b = 5; p1_req_op = 3'b100; p1_req_valid = 1;
      for (int i = 0; i < 30; i++) begin
        if (got_q0.size() == r + 1 && got_q1.size() == r + 1) break;
        cycle();
        if (acc0) p0_req_valid = 0;
        if (acc1) p1_req_valid = 0;
      end
    end
    p0_req_valid = 0; p1_req_valid = 0;
    tests++;
    if (grant_log.size() != 4) begin
      fails++; $display("FAIL tie_grants: got %0d grants, expected 4", grant_log.size());
    end
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      tests++;
      if (grant_log[i] != want[i]) begin
        fails++; $display("FAIL tie_order[%0d]: got p%0d, expected p%0d", i, grant_log[i], want[i]);
      end
    end
    while (got_q0.size() > 0 && exp_q0.size() > 0) begin
      rsp_t g, e;
      g = got_q0.pop_front(); e = exp_q0.pop_front();
      tests++;
      if (g !== e || g.result !== 15) begin fails++; $display("FAIL tie_p0_sb: got %h, expected %h", g, e); end
    end
    while (got_q1.size() > 0 && exp_q1.size() > 0) begin
      rsp_t g, e;
      g = got_q1.pop_front(); e = exp_q1.pop_front();
      tests++;
      if (g !== e || g.result !== 15) begin fails++; $display("FAIL tie_p1_sb: got %h, expected %h", g, e); end
    end
    clear_sb();
  endtask

  task automatic test_backpressure();
    p1_rsp_ready = 0;
    p1_req_a = 1; p1_req_b = 4; p1_req_op = 3'b101; p1_req_valid = 1;
    cycle();
    p1_req_valid = 0;
    p0_req_a = 3; p0_req_b = 4; p0_req_op = 3'b000; p0_req_valid = 1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (p1_rsp_valid !== 1'b1 || p1_rsp_result !== 16 || p0_req_ready !== 1'b0 || p0_rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b r=%0d p0_rdy=%b p0_v=%b, expected v=1 r=16 p0_rdy=0 p0_v=0",
                 i, p1_rsp_valid, p1_rsp_result, p0_req_ready, p0_rsp_valid);
      end
      cycle();
    end
    p1_rsp_ready = 1;
    #1;
    tests++;
    if (p0_req_ready !== 1'b0) begin
      fails++; $display("FAIL bp_no_overlap: got p0_req_ready=%b on completing cycle, expected 0", p0_req_ready);
    end
    for (int i = 0; i < 20 && exp_q0.size() == 0; i++) cycle();
    p0_req_valid = 0;
    drain(20);
    tests++;
    if (got_q1.size() != 1 || got_q0.size() != 1) begin
      fails++; $display("FAIL bp_count: got p0=%0d p1=%0d responses, expected 1 each", got_q0.size(), got_q1.size());
    end
    while (got_q1.size() > 0 && exp_q1.size() > 0) begin
      rsp_t g, e;
      g = got_q1.pop_front(); e = exp_q1.pop_front();
      tests++;
      if (g !== e) begin fails++; $display("FAIL bp_p1_sb: got %h, expected %h", g, e); end
    end
    while (got_q0.size() > 0 && exp_q0.size() > 0) begin
      rsp_t g, e;
      g = got_q0.pop_front(); e = exp_q0.pop_front();
      tests++;
      if (g !== e) begin fails++; $display("FAIL bp_p0_sb: got %h, expected %h", g, e); end
    end
    clear_sb();
  endtask

  task automatic test_illegal();
    p0_req_a = 5; p0_req_b = 6; p0_req_op = 3'b111; p0_req_valid = 1;
    for (int i = 0; i < 10 && !acc0; i++) cycle();
    p0_req_valid = 0;
    #1;
    tests++;
    if (alu_op !== 3'b000) begin
      fails++; $display("FAIL illegal_aluop: got %0d in EXEC, expected 0", alu_op);
    end
    cycle();
    #1;
    tests++;
    if (p0_rsp_valid !== 1'b1 || p0_rsp_err !== 1'b1 || p0_rsp_result !== '0) begin
      fails++; $display("FAIL illegal_resp: got v=%b e=%b r=%h, expected v=1 e=1 r=0", p0_rsp_valid, p0_rsp_err, p0_rsp_result);
    end
    drain(10);
    while (got_q0.size() > 0 && exp_q0.size() > 0) begin
      rsp_t g, e;
      g = got_q0.pop_front(); e = exp_q0.pop_front();
      tests++;
      if (g !== e) begin fails++; $display("FAIL illegal_sb: got %h, expected %h", g, e); end
    end
    clear_sb();
  endtask

  task automatic test_reset_mid();
    p0_rsp_ready = 0;
    p0_req_a = 32'hFFFF_FFFF; p0_req_b = 0; p0_req_op = 3'b000; p0_req_valid = 1;
    for (int i = 0; i < 10 && !acc0; i++) cycle();
    p0_req_valid = 0;
    cycle();
    #1;
    tests++;
    if (p0_rsp_valid !== 1'b1 || p0_rsp_result !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL rstmid_pre: got v=%b r=%h, expected v=1 r=ffffffff", p0_rsp_valid, p0_rsp_result);
    end
    rst = 1;
    cycle();
    rst = 0;
    #1;
    tests++;
    if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00 || p0_rsp_result !== '0) begin
      fails++; $display("FAIL rstmid_post: got v0=%b v1=%b r=%h, expected 0 0 0", p0_rsp_valid, p1_rsp_valid, p0_rsp_result);
    end
    p0_rsp_ready = 1;
    for (int i = 0; i < 6; i++) cycle();
    tests++;
    if (got_q0.size() != 0 || got_q1.size() != 0) begin
      fails++; $display("FAIL rstmid_silent: got %0d late responses, expected 0", got_q0.size() + got_q1.size());
    end
    clear_sb();
  endtask

  task automatic test_wrap_back_to_back();
    logic [W-1:0] av[4] = '{32'hFFFF_FFFF, 32'd7, 32'h0000_00F0, 32'h8000_0000};
    logic [W-1:0] bv[4] = '{32'd1, 32'd3, 32'h0000_000F, 32'd31};
    logic [2:0]   ov[4] = '{3'b000, 3'b001, 3'b011, 3'b110};
    int idx = 0;
    p0_req_a = av[0]; p0_req_b = bv[0]; p0_req_op = ov[0]; p0_req_valid = 1;
    for (int i = 0; i < 40 && idx < 4; i++) begin
      cycle();
      if (acc0) begin
        idx++;
        if (idx < 4) begin p0_req_a = av[idx]; p0_req_b = bv[idx]; p0_req_op = ov[idx]; end
        else p0_req_valid = 0;
      end
    end
    p0_req_valid = 0;
    drain(20);
    tests++;
    if (acc_cyc.size() != 4 || got_q0.size() != 4) begin
      fails++; $display("FAIL b2b_count: got %0d accepts %0d responses, expected 4 4", acc_cyc.size(), got_q0.size());
    end
    for (int i = 0; i + 1 < acc_cyc.size(); i++) begin
      tests++;
      if (acc_cyc[i+1] - acc_cyc[i] != 3) begin
        fails++; $display("FAIL b2b_spacing[%0d]: got %0d cycles, expected 3", i, acc_cyc[i+1] - acc_cyc[i]);
      end
    end
    if (got_q0.size() > 0) begin
      tests++;
      if (got_q0[0] !== '{err: 1'b0, result: 32'h0}) begin
        fails++; $display("FAIL wrap_add: got %h, expected err=0 result=0", got_q0[0]);
      end
    end
    while (got_q0.size() > 0 && exp_q0.size() > 0) begin
      rsp_t g, e;
      g = got_q0.pop_front(); e = exp_q0.pop_front();
      tests++;
      if (g !== e) begin fails++; $display("FAIL b2b_sb: got %h, expected %h", g, e); end
    end
    clear_sb();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    @(negedge clk);
    test_reset();
    test_p0_only();
    test_tie();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_wrap_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters, for example the integer execute path and a future address/branch-compare unit. Each requester uses a valid/ready request channel and a valid/ready response channel. Operands are latched, driven to the shared ALU for one cycle, and the result is registered and returned to the owning requester. Arbitration is round-robin, with one operation outstanding at a time.

Parameters:
WIDTH, 32, operand/result width
OP_W, 3, ALU opcode width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
p0_req_valid  in  1  requester 0 has an operation
p0_req_ready  out  1  requester 0 operation accepted this cycle
p0_req_a  in  WIDTH  requester 0 operand A
p0_req_b  in  WIDTH  requester 0 operand B
p0_req_op  in  OP_W  requester 0 ALU opcode
p0_rsp_valid  out  1  result for requester 0 available
p0_rsp_ready  in  1  requester 0 consumes result
p0_rsp_result  out  WIDTH  result for requester 0
p0_rsp_err  out  1  opcode was illegal (3'b111)
p1_*  same set as p0_* for requester 1
alu_a  out  WIDTH  to shared ALU A
alu_b  out  WIDTH  to shared ALU B
alu_op  out  OP_W  to shared ALU ALUOp
alu_result  in  WIDTH  from shared ALU result (combinational)

Behaviour:
- Clock and reset are decided: one clock; reset is synchronous and active-high, ports clk and rst.
- ALU opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 illegal.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - pN_req_ready = 1 only for the granted port, and only if that port's req_valid = 1.
  - Grant rules:
    - Only p0 valid -> p0.
    - Only p1 valid -> p1.
    - Both valid -> the port not granted last (owner != last_owner).
  - On handshake: latch a, b, op and owner; set last_owner = owner; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_op driven from the latch.
  - At the clock edge: result_reg <= alu_result; err_reg <= (op == 3'b111); go to RESP.
  - On illegal op, result_reg <= 0 and alu_op is driven as 000.
- RESP:
  - owner's rsp_valid = 1; result and err are held stable.
  - Other port's rsp_valid = 0.
  - On owner's rsp_ready = 1 -> IDLE at that edge.
  - rsp_valid and rsp_ready are independent of each other; rsp_ready may be high early.
- All req_ready = 0 in EXEC and RESP; no new acceptance in the same cycle RESP completes.
- Latency and throughput:
  - Request accepted at edge N -> rsp_valid high in the cycle after edge N+1.
  - Minimum 3 cycles per op with rsp_ready held high.
- When not in EXEC, alu_a/alu_b hold the last latched values (no X).
- Reset values:
  - state = IDLE; last_owner = 1 (so p0 wins the first tie).
  - Latches and result_reg = 0.
  - All req_ready, rsp_valid and rsp_err = 0.
  - alu_a = alu_b = 0; alu_op = 000.
- Reset mid-operation (EXEC or RESP) discards the operation silently; no response is issued after reset.
- A requester dropping req_valid before its handshake is legal and produces no operation.
- Requester fairness: under continuous contention the grants alternate p0, p1, p0, ...
- Results are WIDTH bits; ALU wrap-around (e.g. overflow on ADD) is passed through unmodified.

Decomposition:
- Package alu_pkg holds:
  - ALU opcode localparams (ALU_ADD..ALU_SRL, ALU_ILLEGAL).
  - FSM state encoding (S_IDLE, S_EXEC, S_RESP, 2-bit).
  - WIDTH default.
- One sub-module, rr_arb2:
  - Pure combinational 2-way round-robin grant from {req1, req0} and last_owner.
  - Outputs a one-hot grant.
- The FSM, latches and response muxing stay in alu_arbiter.

Test Plan:
- Reset, then p0 only: a=10, b=5, op=001 -> p0_req_ready high in cycle 0; p0_rsp_valid high 2 cycles later with result=5, err=0; p1 outputs stay 0.
- Both valid simultaneously after reset: p0 op=000 10+5, p1 op=100 10^5 -> p0 served first (15), then p1 (15). Repeat both valid -> p0 served first again, since last_owner = p1.
- Backpressure: p1 op=101 a=1 b=4 with p1_rsp_ready=0 for 5 cycles -> p1_rsp_valid stays high, result 16 stable; p0_req_ready stays 0 throughout; response completes when rsp_ready rises.
- Illegal op 111 on p0 -> p0_rsp_err=1, result=0, alu_op observed as 000 in EXEC.
- Reset asserted during RESP holding result 0xFFFFFFFF (ADD 0xFFFFFFFF + 0) -> next cycle all rsp_valid = 0, state IDLE; no response appears afterwards.
- Wrap-around: ADD 0xFFFFFFFF + 1 -> result 0, err 0. Back-to-back p0 requests with rsp_ready tied high -> one accept every 3 cycles.
